// File: rtl/proc_pkg.sv
// Shared encodings for the unified-memory arbiter: access sizes, grant owners
// and the arbiter FSM states.
package proc_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b01;
    localparam logic [1:0] SZ_HALF  = 2'b10;
    localparam logic [1:0] SZ_WORD  = 2'b11;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for sub-word accesses: enables, alignment check,
// store-data placement and load-data extraction.
module mem_lane
    import proc_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic        misaligned_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] mask;
    logic [4:0]  shamt;

    assign shamt = {off_i, 3'b000};

    // Size 00 is not a legal encoding and falls into the word case.
    always_comb begin
        be_o         = 4'b1111;
        misaligned_o = 1'b0;
        mask         = 32'hFFFF_FFFF;
        case (size_i)
            SZ_BYTE: begin
                be_o = 4'b0001 << off_i;
                mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                be_o         = 4'b0011 << off_i;
                misaligned_o = off_i[0];
                mask         = 32'h0000_FFFF;
            end
            default: begin
                be_o         = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
        endcase
    end

    assign wdata_o = wdata_i << shamt;
    assign rdata_o = (rdata_i >> shamt) & mask;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and load/store:
// MEM-priority arbitration with an IF starvation guard and a req/ack RAM port.
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_abort_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_rdata_i,
    output logic [1:0]  grant_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t     state_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic [1:0]     grant_q, size_q, off_q;
    logic           we_q, abort_q;
    logic           if_ack_q, mem_ack_q, mem_err_q;
    logic [31:0]    if_rdata_q, mem_rdata_q;
    logic           ram_req_q, ram_we_q;
    logic [3:0]     ram_be_q;
    logic [31:0]    ram_addr_q, ram_wdata_q;

    logic [1:0]     lane_size, lane_off;
    logic [3:0]     lane_be;
    logic           lane_misaligned;
    logic [31:0]    lane_wdata, lane_rdata;
    logic           if_ok, mem_ok, mem_win, if_win;

    // Live request decodes the lanes while idle; the latched access does afterwards.
    assign lane_size = (state_q == ST_IDLE) ? mem_size_i      : size_q;
    assign lane_off  = (state_q == ST_IDLE) ? mem_addr_i[1:0] : off_q;

    mem_lane u_lane (
        .size_i       (lane_size),
        .off_i        (lane_off),
        .wdata_i      (mem_wdata_i),
        .rdata_i      (ram_rdata_i),
        .be_o         (lane_be),
        .misaligned_o (lane_misaligned),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata)
    );

    assign if_ok   = if_req_i & ~if_abort_i & ~if_ack_o;
    assign mem_ok  = mem_req_i & ~mem_ack_o;
    assign mem_win = mem_ok & ~((starve_cnt_q == CNT_MAX) & if_ok);
    assign if_win  = if_ok & ~mem_win;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            grant_q      <= GNT_NONE;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            we_q         <= 1'b0;
            abort_q      <= 1'b0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            mem_err_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_be_q     <= 4'b0000;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    grant_q <= GNT_NONE;
                    if (mem_win) begin
                        grant_q <= GNT_MEM;
                        we_q    <= mem_we_i;
                        size_q  <= mem_size_i;
                        off_q   <= mem_addr_i[1:0];
                        if (!if_req_i)
                            starve_cnt_q <= '0;
                        else if (starve_cnt_q != CNT_MAX)
                            starve_cnt_q <= starve_cnt_q + 1'b1;
                        if (lane_misaligned) begin
                            mem_ack_q   <= 1'b1;
                            mem_err_q   <= 1'b1;
                            mem_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end else begin
                            mem_err_q   <= 1'b0;
                            ram_req_q   <= 1'b1;
                            ram_we_q    <= mem_we_i;
                            ram_be_q    <= lane_be;
                            ram_addr_q  <= mem_addr_i & ~32'h3;
                            ram_wdata_q <= lane_wdata;
                            state_q     <= ST_BUSY;
                        end
                    end else if (if_win) begin
                        grant_q      <= GNT_IF;
                        starve_cnt_q <= '0;
                        abort_q      <= 1'b0;
                        we_q         <= 1'b0;
                        ram_req_q    <= 1'b1;
                        ram_we_q     <= 1'b0;
                        ram_be_q     <= 4'b1111;
                        ram_addr_q   <= if_addr_i & ~32'h3;
                        ram_wdata_q  <= '0;
                        state_q      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (grant_q == GNT_IF && if_abort_i)
                        abort_q <= 1'b1;
                    if (ram_ack_i) begin
                        ram_req_q <= 1'b0;
                        state_q   <= ST_RESP;
                        if (grant_q == GNT_IF) begin
                            if_rdata_q <= ram_rdata_i;
                            if_ack_q   <= ~(abort_q | if_abort_i);
                        end else begin
                            mem_rdata_q <= we_q ? 32'h0 : lane_rdata;
                            mem_ack_q   <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    grant_q <= GNT_NONE;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= GNT_NONE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A branch flush in the response cycle still squashes the fetch.
    assign if_ack_o    = if_ack_q & ~if_abort_i;
    assign if_rdata_o  = if_rdata_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_err_o   = mem_err_q;
    assign ram_req_o   = ram_req_q;
    assign ram_we_o    = ram_we_q;
    assign ram_be_o    = ram_be_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, lane steering, misalignment,
// starvation ordering, fetch abort and asynchronous reset.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_abort_i = 1'b0;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_size_i = 2'b11;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_ack_i = 1'b0;
    logic [31:0] ram_rdata_i = '0;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;
    logic auto_ram = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_abort_i  (if_abort_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_size_i  (mem_size_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_ack_o   (mem_ack_o),
        .mem_rdata_o (mem_rdata_o),
        .mem_err_o   (mem_err_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_ack_i   (ram_ack_i),
        .ram_rdata_i (ram_rdata_i),
        .grant_o     (grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock step; samples land 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (auto_ram) ram_ack_i = ram_req_o;
    endtask

    logic [1:0] seen [10];
    logic [1:0] exp_order [10];
    logic [1:0] prev_gnt;
    int         n_seen;

    initial begin
        // Reset
        tick(); tick();
        chk("rst ram_req", 32'(ram_req_o), 32'd0);
        chk("rst grant", 32'(grant_o), 32'd0);
        chk("rst mem_ack", 32'(mem_ack_o), 32'd0);
        chk("rst if_ack", 32'(if_ack_o), 32'd0);
        chk("rst ram_be", 32'(ram_be_o), 32'd0);
        chk("rst mem_rdata", mem_rdata_o, 32'd0);
        rst_i = 1'b0;
        tick();
        $display("txn reset released");

        // Word load at 0x10, RAM acks in cycle 1
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b11; mem_addr_i = 32'h10;
        tick();
        chk("ldw ram_req c1", 32'(ram_req_o), 32'd1);
        chk("ldw ram_be", 32'(ram_be_o), 32'hF);
        chk("ldw ram_addr", ram_addr_o, 32'h10);
        chk("ldw ram_we", 32'(ram_we_o), 32'd0);
        chk("ldw grant", 32'(grant_o), 32'd2);
        chk("ldw no early ack", 32'(mem_ack_o), 32'd0);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hDEADBEEF;
        tick();
        chk("ldw mem_ack c2", 32'(mem_ack_o), 32'd1);
        chk("ldw rdata", mem_rdata_o, 32'hDEADBEEF);
        chk("ldw err", 32'(mem_err_o), 32'd0);
        chk("ldw ram_req dropped", 32'(ram_req_o), 32'd0);
        ram_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        chk("ldw ack pulse", 32'(mem_ack_o), 32'd0);
        chk("ldw grant idle", 32'(grant_o), 32'd0);
        $display("txn load word 0x10 -> %h", 32'hDEADBEEF);

        // Byte store 0xAB at 0x13
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b01; mem_addr_i = 32'h13; mem_wdata_i = 32'hAB;
        tick();
        chk("stb ram_be", 32'(ram_be_o), 32'h8);
        chk("stb ram_wdata", ram_wdata_o, 32'hAB000000);
        chk("stb ram_addr", ram_addr_o, 32'h10);
        chk("stb ram_we", 32'(ram_we_o), 32'd1);
        ram_ack_i = 1'b1;
        tick();
        chk("stb mem_ack", 32'(mem_ack_o), 32'd1);
        chk("stb err", 32'(mem_err_o), 32'd0);
        ram_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        $display("txn store byte 0xab at 0x13");

        // Byte load at 0x13
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b01; mem_addr_i = 32'h13;
        tick();
        chk("ldb ram_be", 32'(ram_be_o), 32'h8);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hAB112233;
        tick();
        chk("ldb mem_ack", 32'(mem_ack_o), 32'd1);
        chk("ldb rdata", mem_rdata_o, 32'h000000AB);
        ram_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        $display("txn load byte 0x13 -> %h", 32'h000000AB);

        // Half load at 0x12
        mem_req_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h12;
        tick();
        chk("ldh ram_be", 32'(ram_be_o), 32'hC);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hAB112233;
        tick();
        chk("ldh rdata", mem_rdata_o, 32'h0000AB11);
        ram_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        $display("txn load half 0x12 -> %h", 32'h0000AB11);

        // Size 00 treated as word
        mem_req_i = 1'b1; mem_size_i = 2'b00; mem_addr_i = 32'h14;
        tick();
        chk("sz00 ram_be", 32'(ram_be_o), 32'hF);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hCAFEF00D;
        tick();
        chk("sz00 rdata", mem_rdata_o, 32'hCAFEF00D);
        ram_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        $display("txn load size00 0x14 -> %h", 32'hCAFEF00D);

        // Misaligned half at 0x21
        mem_req_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h21;
        tick();
        chk("mis ram_req", 32'(ram_req_o), 32'd0);
        chk("mis mem_ack c1", 32'(mem_ack_o), 32'd1);
        chk("mis err", 32'(mem_err_o), 32'd1);
        chk("mis rdata", mem_rdata_o, 32'd0);
        mem_req_i = 1'b0;
        tick();
        chk("mis ack pulse", 32'(mem_ack_o), 32'd0);
        chk("mis grant idle", 32'(grant_o), 32'd0);
        chk("mis ram_req idle", 32'(ram_req_o), 32'd0);
        $display("txn misaligned half 0x21 -> err");

        // Fetch at 0x43, low address bits ignored
        if_req_i = 1'b1; if_addr_i = 32'h43;
        tick();
        chk("if ram_addr", ram_addr_o, 32'h40);
        chk("if ram_be", 32'(ram_be_o), 32'hF);
        chk("if grant", 32'(grant_o), 32'd1);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h12345678;
        tick();
        chk("if ack", 32'(if_ack_o), 32'd1);
        chk("if rdata", if_rdata_o, 32'h12345678);
        ram_ack_i = 1'b0; if_req_i = 1'b0;
        tick();
        $display("txn fetch 0x40 -> %h", 32'h12345678);

        // Abort in IDLE keeps IF out of arbitration
        if_req_i = 1'b1; if_addr_i = 32'h60; if_abort_i = 1'b1;
        tick();
        chk("abort idle grant", 32'(grant_o), 32'd0);
        chk("abort idle ram_req", 32'(ram_req_o), 32'd0);
        if_abort_i = 1'b0;
        tick();
        chk("post abort grant", 32'(grant_o), 32'd1);
        ram_ack_i = 1'b1;
        tick();
        chk("post abort if_ack", 32'(if_ack_o), 32'd1);
        ram_ack_i = 1'b0; if_req_i = 1'b0;
        tick();
        $display("txn fetch 0x60 after idle abort");

        // Abort during BUSY, RAM acks 3 cycles later
        if_req_i = 1'b1; if_addr_i = 32'h80;
        tick();
        chk("abusy ram_req c1", 32'(ram_req_o), 32'd1);
        if_abort_i = 1'b1;
        tick();
        if_abort_i = 1'b0; if_req_i = 1'b0;
        chk("abusy ram_req c2", 32'(ram_req_o), 32'd1);
        tick();
        chk("abusy ram_req c3", 32'(ram_req_o), 32'd1);
        chk("abusy addr held", ram_addr_o, 32'h80);
        tick();
        chk("abusy ram_req c4", 32'(ram_req_o), 32'd1);
        ram_ack_i = 1'b1;
        tick();
        ram_ack_i = 1'b0;
        chk("abusy if_ack suppressed", 32'(if_ack_o), 32'd0);
        chk("abusy ram_req dropped", 32'(ram_req_o), 32'd0);
        tick();
        chk("abusy if_ack after", 32'(if_ack_o), 32'd0);
        chk("abusy back idle", 32'(grant_o), 32'd0);
        $display("txn fetch 0x80 aborted in busy");

        // Starvation guard: both held
        exp_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        if_req_i = 1'b1; if_addr_i = 32'h100;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b11; mem_addr_i = 32'h200;
        auto_ram = 1'b1;
        prev_gnt = 2'd0;
        n_seen = 0;
        for (int i = 0; i < 60 && n_seen < 10; i++) begin
            tick();
            if (grant_o != 2'd0 && prev_gnt == 2'd0) begin
                seen[n_seen] = grant_o;
                n_seen++;
            end
            prev_gnt = grant_o;
        end
        chk("starve grant count", 32'(n_seen), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < n_seen) chk($sformatf("starve order %0d", i), 32'(seen[i]), 32'(exp_order[i]));
            $display("txn starve grant %0d = %0d", i, (i < n_seen) ? seen[i] : 2'd0);
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        auto_ram = 1'b0; ram_ack_i = 1'b0;
        tick();
        chk("starve drained", 32'(grant_o), 32'd0);

        // Asynchronous reset during BUSY
        mem_req_i = 1'b1; mem_size_i = 2'b11; mem_addr_i = 32'h30;
        tick();
        chk("arst pre ram_req", 32'(ram_req_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst ram_req", 32'(ram_req_o), 32'd0);
        chk("arst grant", 32'(grant_o), 32'd0);
        chk("arst ram_be", 32'(ram_be_o), 32'd0);
        chk("arst ram_addr", ram_addr_o, 32'd0);
        chk("arst mem_rdata", mem_rdata_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("arst fresh ram_req", 32'(ram_req_o), 32'd1);
        chk("arst fresh addr", ram_addr_o, 32'h30);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h0BADF00D;
        tick();
        chk("arst fresh ack", 32'(mem_ack_o), 32'd1);
        chk("arst fresh rdata", mem_rdata_o, 32'h0BADF00D);
        ram_ack_i = 1'b0; mem_req_i = 1'b0;
        tick();
        $display("txn reset in busy then load 0x30 -> %h", 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-port unified instruction/data memory shared between the IF stage (instruction fetch) and the MEM stage (load/store). Arbitrates fixed-priority-to-MEM with a starvation guard for IF, runs a req/ack handshake toward the RAM, generates byte enables, rejects misaligned data accesses and discards fetches squashed by a taken branch. The IF and MEM stages derive their stalls from `req & ~ack`.

## Interface
- `STARVE_MAX`, 4: consecutive MEM grants allowed while IF waits before IF is forced.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` until `if_ack_o`.
- `if_addr_i`  in  32  fetch address, word aligned; bits [1:0] ignored.
- `if_abort_i`  in  1  taken-branch flush; cancels the current fetch.
- `if_ack_o`  out  1  one-cycle fetch completion pulse.
- `if_rdata_o`  out  32  instruction word, valid with `if_ack_o`.
- `mem_req_i`  in  1  data request; all `mem_*` inputs held until `mem_ack_o`.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  2  01 byte, 10 half, 11 word; 00 illegal, treated as word.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  store data, LSB-justified.
- `mem_ack_o`  out  1  one-cycle data completion pulse.
- `mem_rdata_o`  out  32  load data, zero-extended and LSB-justified; valid with `mem_ack_o`.
- `mem_err_o`  out  1  misaligned access; valid with `mem_ack_o`.
- `ram_req_o`  out  1  RAM request; held with all `ram_*` outputs until `ram_ack_i`.
- `ram_we_o`  out  1  write enable.
- `ram_be_o`  out  4  byte enables.
- `ram_addr_o`  out  32  word address, bits [1:0] = 0.
- `ram_wdata_o`  out  32  lane-shifted store data.
- `ram_ack_i`  in  1  one-cycle pulse; `ram_rdata_i` is valid in the same cycle.
- `ram_rdata_i`  in  32  read word.
- `grant_o`  out  2  current owner: 00 none, 01 IF, 10 MEM.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - BUSY: wait for `ram_ack_i`.
  - RESP: pulse the ack.
- IDLE arbitration:
  - MEM wins if `mem_req_i`, unless `starve_cnt == STARVE_MAX` and `if_req_i`, in which case IF wins.
  - A requester whose ack is asserted in this cycle is excluded.
- Starvation counter `starve_cnt`:
  - Increments on each MEM grant while `if_req_i` is high, saturating at `STARVE_MAX`.
  - Clears on any IF grant, or on a MEM grant while `if_req_i` is low.
- Misaligned MEM access (half with addr[0]=1, word with addr[1:0]≠0):
  - No RAM cycle is issued.
  - IDLE goes directly to RESP with `mem_err_o=1` and `mem_rdata_o=0`.
- Grant: latch owner, address, `ram_be_o` and `ram_wdata_o` into registers, assert `ram_req_o`, go to BUSY.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << addr[1:0]`.
  - word: `4'b1111`.
  - IF: `4'b1111`.
- Store data is shifted left by `8*addr[1:0]`.
- BUSY:
  - On `ram_ack_i`: drop `ram_req_o` and capture the read data.
  - For a load, the captured data is shifted right by `8*addr[1:0]`, masked to the access size and zero-extended.
  - Then go to RESP.
- RESP: pulse the owner's ack for one cycle, go to IDLE, set `grant_o=00`.
- IF abort:
  - `if_abort_i` while IF owns BUSY: the RAM cycle completes (`ram_req_o` is never withdrawn) and `if_ack_o` is suppressed in RESP.
  - `if_abort_i` in RESP suppresses `if_ack_o` in that cycle.
  - `if_abort_i` in IDLE excludes IF from arbitration in that cycle.

## Timing
- Reset values: all outputs 0, state IDLE, `starve_cnt` 0, capture registers 0.
- Reset mid-transaction drops `ram_req_o` immediately. The RAM model must tolerate an abandoned request.
- Latency from request seen in IDLE (cycle 0):
  - `ram_req_o` is high in cycle 1.
  - With `ram_ack_i` in cycle k ≥ 1, the ack is in cycle k+1.
  - Minimum is 2 cycles; a misaligned access acks in cycle 1.
- Throughput: one access per 3 cycles minimum (IDLE, BUSY, RESP).
- IF and MEM requests arriving in the same cycle: MEM first unless starvation is forced. IF is then granted in the IDLE following MEM's RESP.
- `ram_*` outputs are registered and stay stable from `ram_req_o` rise until the cycle after `ram_ack_i`.

## Structure
- Shared package `proc_pkg` holds:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - Grant encodings `GNT_NONE`, `GNT_IF`, `GNT_MEM`.
  - The `arb_state_t` enum.
- Sub-module `mem_lane`, combinational. Inputs: size and addr[1:0]. Outputs: `be`, `misaligned`, store shift and load extract.
- Top level holds the FSM, the starvation counter and the output registers.

## Test plan
- MEM load size 11 at addr 0x10, RAM acks 1 cycle after request with 0xDEADBEEF -> `ram_be_o=1111`, `mem_ack_o` in cycle 2, `mem_rdata_o=0xDEADBEEF`.
- Store byte 0xAB at addr 0x13 -> `ram_be_o=1000`, `ram_wdata_o=0xAB000000`, `ram_addr_o=0x10`. Load byte at 0x13 returning 0xAB112233 -> `mem_rdata_o=0x000000AB`.
- Half load at 0x21 -> no `ram_req_o`, `mem_ack_o` with `mem_err_o=1` in cycle 1.
- `if_req_i` and `mem_req_i` held continuously, `STARVE_MAX=4` -> grant order MEM×4, IF, MEM×4, IF.
- IF in BUSY, `if_abort_i` pulsed, RAM acks 3 cycles later -> `ram_req_o` held until the ack, `if_ack_o` never asserted, FSM returns to IDLE.
- `rst_i` asserted during BUSY -> all outputs 0 asynchronously. After release, a fresh MEM load completes normally.
